sargantana_icache_repl_sel: RTL and testbench

Parametrised victim-way selector for the instruction cache refill path. It generalises the fixed 8-bit LFSR way picker in three ways: configurable LFSR width, runtime-selectable policy (LFSR random, round-robin, tree pseudo-LRU), and invalid-way-first allocation. It sits between the icache controller's refill request and the tag/data write enables. It returns one registered victim per request, with 1-cycle latency and full throughput.

---
 rtl/sargantana_icache_pkg.sv | 23 ++
 rtl/sargantana_icache_plru_tree.sv | 37 +++
 rtl/sargantana_icache_repl_sel.sv | 135 +++++++++++++
 tb/tb_sargantana_icache_repl_sel.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared types and helpers for the icache victim-way selector.
// Holds the policy encoding and the LFSR tap masks.
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        REPL_LFSR = 2'd0,
        REPL_RR   = 2'd1,
        REPL_PLRU = 2'd2
    } repl_mode_e;

    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // Tap masks for maximal-length XNOR Fibonacci LFSRs; zero marks an unsupported width.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_008E;
            16:      return 32'h0000_D008;
            32:      return 32'h8020_0003;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/sargantana_icache_plru_tree.sv
// Combinational tree pseudo-LRU: walks the tree to the victim way and computes the
// state after touching a way (path nodes flipped to point away from it).
module sargantana_icache_plru_tree #(
    parameter  int ICACHE_N_WAY = 4,
    localparam int WAY_W        = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1
) (
    input  logic [ICACHE_N_WAY-2:0] state,
    input  logic [WAY_W-1:0]        touch_way,
    output logic [WAY_W-1:0]        victim,
    output logic [ICACHE_N_WAY-2:0] state_next
);

    logic [ICACHE_N_WAY-2:0] walk;

    // Level l nodes start at index 2^l-1; the path prefix so far selects the node within the level.
    always_comb begin
        walk   = '0;
        victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            walk   = state >> ((1 << l) - 1 + int'(victim));
            victim = (victim << 1) | WAY_W'(walk[0]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ICACHE_N_WAY - 1; gi++) begin : g_node
            localparam int LVL = $clog2(gi + 2) - 1;
            localparam int POS = gi + 1 - (1 << LVL);
            logic on_path;

            assign on_path        = (int'(touch_way >> (WAY_W - LVL)) == POS);
            assign state_next[gi] = on_path ? ~touch_way[WAY_W-1-LVL] : state[gi];
        end
    endgenerate

endmodule

// File: rtl/sargantana_icache_repl_sel.sv
// Icache refill victim-way selector: invalid-way-first, then LFSR, round-robin or
// tree PLRU. One registered victim per request, 1-cycle latency, no stall.
module sargantana_icache_repl_sel
    import sargantana_icache_pkg::*;
#(
    parameter  int                    ICACHE_N_WAY = 4,
    parameter  int                    LFSR_WIDTH   = 8,
    parameter  logic [LFSR_WIDTH-1:0] LFSR_SEED    = '0,
    localparam int                    WAY_W        = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              mode_i,
    input  logic                    req_i,
    input  logic [ICACHE_N_WAY-1:0] valid_ways_i,
    input  logic                    hit_i,
    input  logic [WAY_W-1:0]        hit_way_i,
    input  logic                    flush_i,
    output logic [WAY_W-1:0]        way_o,
    output logic                    way_valid_o
);

    localparam logic [LFSR_MAX_WIDTH-1:0] TAPS_ALL = lfsr_taps(LFSR_WIDTH);

    generate
        if (ICACHE_N_WAY < 1 || ICACHE_N_WAY > 16 ||
            (ICACHE_N_WAY & (ICACHE_N_WAY - 1)) != 0) begin : g_bad_ways
            $error("ICACHE_N_WAY must be a power of two in 1..16");
        end
        if (LFSR_WIDTH != 8 && LFSR_WIDTH != 16 && LFSR_WIDTH != 32) begin : g_bad_lfsr
            $error("LFSR_WIDTH must be 8, 16 or 32");
        end
        if (LFSR_SEED == '1) begin : g_bad_seed
            $error("LFSR_SEED must not be all-ones");
        end

        if (ICACHE_N_WAY == 1) begin : g_direct
            assign way_o = '0;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    way_valid_o <= 1'b0;
                end else begin
                    way_valid_o <= req_i;
                end
            end
        end else begin : g_assoc
            localparam logic [LFSR_WIDTH-1:0] TAPS = TAPS_ALL[LFSR_WIDTH-1:0];

            logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_next;
            logic [WAY_W-1:0]        rr_q;
            logic [ICACHE_N_WAY-2:0] plru_q, plru_hit_next, plru_after_hit, plru_refill_next, plru_next;
            logic [WAY_W-1:0]        plru_victim, refill_victim_unused;
            logic [WAY_W-1:0]        first_inv, victim;
            logic                    any_inv;
            logic [WAY_W-1:0]        way_reg;
            logic                    way_valid_reg;

            assign lfsr_next = {lfsr_q[LFSR_WIDTH-2:0], ~^(lfsr_q & TAPS)};

            // Hit touch first, then the refill touch on top of it, so refill wins shared nodes.
            sargantana_icache_plru_tree #(.ICACHE_N_WAY(ICACHE_N_WAY)) u_hit_tree (
                .state      (plru_q),
                .touch_way  (hit_way_i),
                .victim     (plru_victim),
                .state_next (plru_hit_next)
            );

            assign plru_after_hit = hit_i ? plru_hit_next : plru_q;

            sargantana_icache_plru_tree #(.ICACHE_N_WAY(ICACHE_N_WAY)) u_refill_tree (
                .state      (plru_after_hit),
                .touch_way  (victim),
                .victim     (refill_victim_unused),
                .state_next (plru_refill_next)
            );

            assign plru_next = req_i ? plru_refill_next : plru_after_hit;

            always_comb begin
                first_inv = '0;
                for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
                    if (!valid_ways_i[i]) begin
                        first_inv = WAY_W'(i);
                    end
                end
            end

            assign any_inv = ~&valid_ways_i;

            always_comb begin
                victim = lfsr_q[WAY_W-1:0];
                if (any_inv) begin
                    victim = first_inv;
                end else begin
                    case (mode_i)
                        REPL_RR:   victim = rr_q;
                        REPL_PLRU: victim = plru_victim;
                        default:   victim = lfsr_q[WAY_W-1:0];
                    endcase
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lfsr_q        <= LFSR_SEED;
                    rr_q          <= '0;
                    plru_q        <= '0;
                    way_reg       <= '0;
                    way_valid_reg <= 1'b0;
                end else begin
                    way_valid_reg <= req_i;
                    if (req_i) begin
                        way_reg <= victim;
                        lfsr_q  <= lfsr_next;
                    end
                    // Power-of-two way count lets the increment wrap naturally.
                    if (flush_i) begin
                        rr_q   <= '0;
                        plru_q <= '0;
                    end else begin
                        if (req_i) begin
                            rr_q <= rr_q + 1'b1;
                        end
                        plru_q <= plru_next;
                    end
                end
            end

            assign way_o       = way_reg;
            assign way_valid_o = way_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sargantana_icache_repl_sel.sv
// Self-checking bench: directed scenarios plus random traffic on a 4-way/8-bit and an
// 8-way/16-bit selector, compared against a behavioural model of the selection rules.
module tb_sargantana_icache_repl_sel;

    logic       clk = 1'b0;
    logic       rst_i, req, hit, flush;
    logic [1:0] mode;
    logic [3:0] valid4;
    logic [7:0] valid8;
    logic [1:0] hw4, way4;
    logic [2:0] hw8, way8;
    logic       vld4, vld8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sargantana_icache_repl_sel #(.ICACHE_N_WAY(4), .LFSR_WIDTH(8), .LFSR_SEED(8'h00)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .mode_i(mode), .req_i(req), .valid_ways_i(valid4),
        .hit_i(hit), .hit_way_i(hw4), .flush_i(flush), .way_o(way4), .way_valid_o(vld4)
    );

    sargantana_icache_repl_sel #(.ICACHE_N_WAY(8), .LFSR_WIDTH(16), .LFSR_SEED(16'h0000)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .mode_i(mode), .req_i(req), .valid_ways_i(valid8),
        .hit_i(hit), .hit_way_i(hw8), .flush_i(flush), .way_o(way8), .way_valid_o(vld8)
    );

    // Reference model state, index 0 = 4-way instance, 1 = 8-way instance.
    int              NW[2] = '{4, 8};
    int              WB[2] = '{2, 3};
    int              LW[2] = '{8, 16};
    longint unsigned m_lfsr[2];
    int              m_rr[2];
    bit [15:0]       m_plru[2];
    int              m_way[2];
    bit              m_vld[2];

    function automatic longint unsigned lfsr_step(longint unsigned s, int w);
        longint unsigned taps;
        longint unsigned fb;
        case (w)
            8:       taps = (64'd1 << 7) | (64'd1 << 3) | (64'd1 << 2) | (64'd1 << 1);
            16:      taps = (64'd1 << 15) | (64'd1 << 14) | (64'd1 << 12) | (64'd1 << 3);
            default: taps = (64'd1 << 31) | (64'd1 << 21) | 64'd3;
        endcase
        fb = ($countones(s & taps) % 2 == 0) ? 64'd1 : 64'd0;
        return ((s << 1) | fb) & ((64'd1 << w) - 1);
    endfunction

    function automatic int plru_pick(bit [15:0] t, int levels);
        int node = 0;
        int way  = 0;
        for (int l = 0; l < levels; l++) begin
            way  = way * 2 + int'(t[node]);
            node = 2 * node + 1 + int'(t[node]);
        end
        return way;
    endfunction

    function automatic bit [15:0] plru_touch(bit [15:0] t, int levels, int w);
        int node = 0;
        int b;
        for (int l = 0; l < levels; l++) begin
            b       = (w >> (levels - 1 - l)) & 1;
            t[node] = (b == 0);
            node    = 2 * node + 1 + b;
        end
        return t;
    endfunction

    function automatic int m_victim(int d, bit [15:0] vw);
        for (int i = 0; i < NW[d]; i++) begin
            if (!vw[i]) return i;
        end
        case (mode)
            2'd1:    return m_rr[d];
            2'd2:    return plru_pick(m_plru[d], WB[d]);
            default: return int'(m_lfsr[d] % longint'(NW[d]));
        endcase
    endfunction

    task automatic model_edge();
        bit [15:0] vw;
        int        v;
        for (int d = 0; d < 2; d++) begin
            if (rst_i) begin
                m_lfsr[d] = 0; m_rr[d] = 0; m_plru[d] = '0; m_way[d] = 0; m_vld[d] = 1'b0;
            end else begin
                vw = (d == 0) ? 16'(valid4) : 16'(valid8);
                v  = m_victim(d, vw);
                if (hit) m_plru[d] = plru_touch(m_plru[d], WB[d], (d == 0) ? int'(hw4) : int'(hw8));
                if (req) begin
                    m_plru[d] = plru_touch(m_plru[d], WB[d], v);
                    m_lfsr[d] = lfsr_step(m_lfsr[d], LW[d]);
                    m_rr[d]   = (m_rr[d] + 1) % NW[d];
                    m_way[d]  = v;
                end
                m_vld[d] = req;
                if (flush) begin
                    m_rr[d]   = 0;
                    m_plru[d] = '0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, let the DUTs take it, compare 1 time unit later.
    task automatic cycle();
        bit was_rst;
        was_rst = rst_i;
        model_edge();
        @(posedge clk);
        #1;
        chk("vld4", 32'(vld4), 32'(m_vld[0]));
        chk("vld8", 32'(vld8), 32'(m_vld[1]));
        if (m_vld[0] || was_rst) chk("way4", 32'(way4), 32'(m_way[0]));
        if (m_vld[1] || was_rst) chk("way8", 32'(way8), 32'(m_way[1]));
    endtask

    task automatic idle();
        rst_i = 1'b0; req = 1'b0; hit = 1'b0; flush = 1'b0;
        valid4 = 4'hF; valid8 = 8'hFF; hw4 = '0; hw8 = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int        exp_lfsr[4];
        int        exp_plru[4];
        int        exp_rr[5];
        bit [7:0]  seen;
        int        dup;
        exp_lfsr = '{0, 1, 3, 2};
        exp_plru = '{0, 2, 1, 3};
        exp_rr   = '{0, 1, 2, 3, 0};

        idle();
        mode = 2'd0;
        #1;

        // LFSR sequence from reset, then full period back to seed.
        do_reset();
        do_reset();
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("lfsr_seq", 32'(way4), 32'(exp_lfsr[i]));
        end
        for (int i = 4; i < 255; i++) cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("lfsr_period", 32'(way4), 32'(exp_lfsr[i]));
        end

        // PLRU order, with a hit on way 1 alongside the 4th refill.
        do_reset();
        mode = 2'd2; req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin hit = 1'b1; hw4 = 2'd1; hw8 = 3'd1; end
            cycle();
            chk("plru_seq", 32'(way4), 32'(exp_plru[i]));
        end
        hit = 1'b0;
        cycle();
        chk("plru_after_hit", 32'(way4), 32'd0);

        // Invalid-way-first under round-robin; counter still advances.
        do_reset();
        mode = 2'd1; req = 1'b1; valid4 = 4'b1011;
        cycle();
        chk("rr_invalid", 32'(way4), 32'd2);
        valid4 = 4'hF;
        cycle();
        chk("rr_after_invalid", 32'(way4), 32'd1);

        // Round-robin wrap and flush with same-cycle request.
        do_reset();
        mode = 2'd1; req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq", 32'(way4), 32'(exp_rr[i]));
        end
        flush = 1'b1;
        cycle();
        chk("rr_flush_req", 32'(way4), 32'd1);
        flush = 1'b0;
        cycle();
        chk("rr_post_flush", 32'(way4), 32'd0);

        // Reset mid-stream with req held high.
        mode = 2'd0;
        rst_i = 1'b1;
        cycle();
        chk("rst_mid_vld", 32'(vld4), 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("lfsr_after_rst", 32'(way4), 32'(exp_lfsr[i]));
        end

        // 8-way PLRU covers every way exactly once in 8 refills.
        do_reset();
        mode = 2'd2; req = 1'b1;
        seen = '0; dup = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (seen[way8]) dup++;
            seen[way8] = 1'b1;
        end
        chk("plru8_cover", 32'(seen), 32'hFF);
        chk("plru8_dup", 32'(dup), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mode   = 2'($urandom_range(0, 3));
            req    = ($urandom % 4) != 0;
            hit    = ($urandom % 3) == 0;
            hw4    = 2'($urandom);
            hw8    = 3'($urandom);
            flush  = ($urandom % 16) == 0;
            rst_i  = ($urandom % 64) == 0;
            valid4 = (($urandom % 3) == 0) ? 4'($urandom) : 4'hF;
            valid8 = (($urandom % 3) == 0) ? 8'($urandom) : 8'hFF;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
